// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline-stage registers: the reset PC,
// per-boundary vector widths and the bit positions of the control fields.
package mips_pipe_pkg;

    localparam logic [31:0] PC_RESET_VEC = 32'h8000_0000;

    localparam int IFID_CTRL_W  = 8;
    localparam int IFID_DATA_W  = 32;
    localparam int IDEX_CTRL_W  = 8;
    localparam int IDEX_DATA_W  = 69;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 69;
    localparam int MEMWB_CTRL_W = 8;
    localparam int MEMWB_DATA_W = 69;

    // Control vector layout: RegWrite, MemRead, MemWrite, MemtoReg[1:0], PCSrc[2:0]
    localparam int CTRL_RW       = 0;
    localparam int CTRL_MR       = 1;
    localparam int CTRL_MW       = 2;
    localparam int CTRL_MTR_LO   = 3;
    localparam int CTRL_MTR_HI   = 4;
    localparam int CTRL_PCSRC_LO = 5;
    localparam int CTRL_PCSRC_HI = 7;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {valid, pc, ctrl, data}. Flush clears valid and ctrl
// and wins over load; pc and data simply keep their old contents.
module pipe_entry_reg
    import mips_pipe_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              CTRL_W   = 8,
    parameter int              DATA_W   = 69,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_i,
    input  logic              clr_valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end else if (clr_valid_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= PC_RESET;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush, optional
// two-entry skid buffer and a saturating stall counter. Outputs come from M only.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(PC_RESET_VEC),
    parameter int              CTRL_W   = IDEX_CTRL_W,
    parameter int              DATA_W   = IDEX_DATA_W,
    parameter int              SKID     = 1,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              inFire;
    logic              mLoad, mClr, mValid;
    logic [PC_W-1:0]   mPcIn, mPc;
    logic [CTRL_W-1:0] mCtrlIn, mCtrl;
    logic [DATA_W-1:0] mDataIn, mData;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    assign inFire = in_valid & in_ready;

    pipe_entry_reg #(
        .PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_RESET(PC_RESET)
    ) uMain (
        .clk(clk), .reset(reset), .flush(flush),
        .load_i(mLoad), .clr_valid_i(mClr),
        .pc_i(mPcIn), .ctrl_i(mCtrlIn), .data_i(mDataIn),
        .valid_o(mValid), .pc_o(mPc), .ctrl_o(mCtrl), .data_o(mData)
    );

    if (SKID != 0) begin : gSkid
        logic              mFree, sLoad, sClr, sValid;
        logic [PC_W-1:0]   sPc;
        logic [CTRL_W-1:0] sCtrl;
        logic [DATA_W-1:0] sData;

        // M can take a new entry when empty or being consumed; S has priority
        // over the input so ordering is preserved.
        assign in_ready = ~sValid;
        assign mFree    = ~mValid | out_ready;
        assign mLoad    = mFree & (sValid | inFire);
        assign mClr     = mFree & ~sValid & ~inFire;
        assign mPcIn    = sValid ? sPc   : in_pc;
        assign mCtrlIn  = sValid ? sCtrl : in_ctrl;
        assign mDataIn  = sValid ? sData : in_data;
        assign sLoad    = inFire & ~mFree;
        assign sClr     = mFree & sValid;

        pipe_entry_reg #(
            .PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_RESET(PC_RESET)
        ) uSkid (
            .clk(clk), .reset(reset), .flush(flush),
            .load_i(sLoad), .clr_valid_i(sClr),
            .pc_i(in_pc), .ctrl_i(in_ctrl), .data_i(in_data),
            .valid_o(sValid), .pc_o(sPc), .ctrl_o(sCtrl), .data_o(sData)
        );
    end else begin : gSingle
        logic outFire;

        assign outFire  = mValid & out_ready;
        assign in_ready = ~mValid | out_ready;
        assign mLoad    = inFire;
        assign mClr     = outFire & ~inFire;
        assign mPcIn    = in_pc;
        assign mCtrlIn  = in_ctrl;
        assign mDataIn  = in_data;
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mValid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    // A bubble must never carry RegWrite/MemWrite downstream.
    assign out_valid = mValid;
    assign out_pc    = mPc;
    assign out_ctrl  = mValid ? mCtrl : '0;
    assign out_data  = mData;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a single-entry instance (a), a skid
// instance (b) and a skid instance with a 3-bit stall counter (c).
module tb_pipe_stage_reg;

    logic clk;
    logic reset;
    logic flush;

    logic        aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aInPc, aOutPc;
    logic [7:0]  aInCtrl, aOutCtrl;
    logic [68:0] aInData, aOutData;
    logic [15:0] aStall;

    logic        bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bInPc, bOutPc;
    logic [7:0]  bInCtrl, bOutCtrl;
    logic [68:0] bInData, bOutData;
    logic [15:0] bStall;

    logic        cInValid, cInReady, cOutValid, cOutReady;
    logic [31:0] cInPc, cOutPc;
    logic [7:0]  cInCtrl, cOutCtrl;
    logic [68:0] cInData, cOutData;
    logic [2:0]  cStall;

    int total;
    int bad;

    pipe_stage_reg #(.SKID(0)) uA (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(aInValid), .in_ready(aInReady),
        .in_pc(aInPc), .in_ctrl(aInCtrl), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady),
        .out_pc(aOutPc), .out_ctrl(aOutCtrl), .out_data(aOutData),
        .stall_cnt(aStall)
    );

    pipe_stage_reg #(.SKID(1)) uB (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(bInValid), .in_ready(bInReady),
        .in_pc(bInPc), .in_ctrl(bInCtrl), .in_data(bInData),
        .out_valid(bOutValid), .out_ready(bOutReady),
        .out_pc(bOutPc), .out_ctrl(bOutCtrl), .out_data(bOutData),
        .stall_cnt(bStall)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(3)) uC (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(cInValid), .in_ready(cInReady),
        .in_pc(cInPc), .in_ctrl(cInCtrl), .in_data(cInData),
        .out_valid(cOutValid), .out_ready(cOutReady),
        .out_pc(cOutPc), .out_ctrl(cOutCtrl), .out_data(cOutData),
        .stall_cnt(cStall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle just after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset with valid traffic offered: reset must dominate.
        reset = 1'b1; flush = 1'b0;
        aInValid = 1'b1; aInPc = 32'h1234; aInCtrl = 8'h5A; aInData = 69'h77; aOutReady = 1'b0;
        bInValid = 1'b1; bInPc = 32'h1234; bInCtrl = 8'h5A; bInData = 69'h77; bOutReady = 1'b0;
        cInValid = 1'b1; cInPc = 32'h1234; cInCtrl = 8'h5A; cInData = 69'h77; cOutReady = 1'b0;
        applyStimulus(1);
        checkOutput("rst_a_valid", aOutValid, 1'b0);
        checkOutput("rst_a_pc",    aOutPc,    32'h8000_0000);
        checkOutput("rst_a_ctrl",  aOutCtrl,  8'h00);
        checkOutput("rst_a_data",  aOutData,  69'h0);
        checkOutput("rst_a_stall", aStall,    16'd0);
        checkOutput("rst_b_valid", bOutValid, 1'b0);
        checkOutput("rst_b_pc",    bOutPc,    32'h8000_0000);
        checkOutput("rst_c_stall", cStall,    3'd0);
        reset = 1'b0;
        aInValid = 1'b0; bInValid = 1'b0; cInValid = 1'b0;

        // Streaming through the single-entry stage.
        aOutReady = 1'b1;
        aInValid = 1'b1; aInPc = 32'h0040_0000; aInCtrl = 8'h11; aInData = 69'h1_0000_0001;
        #1;
        checkOutput("strm_ready0", aInReady, 1'b1);
        applyStimulus(1);
        checkOutput("strm_valid0", aOutValid, 1'b1);
        checkOutput("strm_pc0",    aOutPc,    32'h0040_0000);
        checkOutput("strm_ctrl0",  aOutCtrl,  8'h11);
        checkOutput("strm_data0",  aOutData,  69'h1_0000_0001);
        aInPc = 32'h0040_0004; aInCtrl = 8'h22; aInData = 69'h2;
        #1;
        checkOutput("strm_ready1", aInReady, 1'b1);
        applyStimulus(1);
        checkOutput("strm_pc1",   aOutPc,   32'h0040_0004);
        checkOutput("strm_ctrl1", aOutCtrl, 8'h22);
        aInPc = 32'h0040_0008; aInCtrl = 8'h33; aInData = 69'h3;
        applyStimulus(1);
        checkOutput("strm_pc2",    aOutPc,   32'h0040_0008);
        checkOutput("strm_data2",  aOutData, 69'h3);
        checkOutput("strm_ready2", aInReady, 1'b1);

        // Bubble gating of the control vector.
        aInValid = 1'b0; aInCtrl = 8'hFF;
        applyStimulus(1);
        checkOutput("bub_valid", aOutValid, 1'b0);
        checkOutput("bub_ctrl0", aOutCtrl,  8'h00);
        aInValid = 1'b1;
        applyStimulus(1);
        checkOutput("bub_ctrl1", aOutCtrl, 8'hFF);
        aInValid = 1'b0;
        applyStimulus(1);
        checkOutput("bub_drain", aOutValid, 1'b0);

        // Back-pressure into the skid stage.
        bInValid = 1'b1; bInPc = 32'h0000_0100; bInCtrl = 8'h0A; bInData = 69'hA;
        #1;
        checkOutput("bp_ready0", bInReady, 1'b1);
        applyStimulus(1);
        checkOutput("bp_validA", bOutValid, 1'b1);
        checkOutput("bp_pcA",    bOutPc,    32'h0000_0100);
        checkOutput("bp_stall0", bStall,    16'd0);
        bInPc = 32'h0000_0104; bInCtrl = 8'h0B; bInData = 69'hB;
        applyStimulus(1);
        bInValid = 1'b0;
        checkOutput("bp_full",   bInReady, 1'b0);
        checkOutput("bp_holdA",  bOutPc,   32'h0000_0100);
        checkOutput("bp_stall1", bStall,   16'd1);
        applyStimulus(2);
        checkOutput("bp_stall3", bStall, 16'd3);
        bOutReady = 1'b1;
        applyStimulus(1);
        checkOutput("bp_validB",  bOutValid, 1'b1);
        checkOutput("bp_pcB",     bOutPc,    32'h0000_0104);
        checkOutput("bp_ctrlB",   bOutCtrl,  8'h0B);
        checkOutput("bp_ready1",  bInReady,  1'b1);
        checkOutput("bp_stallH",  bStall,    16'd3);
        applyStimulus(1);
        checkOutput("bp_empty", bOutValid, 1'b0);

        // Flush with both skid entries full and C offered.
        bOutReady = 1'b0;
        bInValid = 1'b1; bInPc = 32'h0000_0200; bInCtrl = 8'h0A; bInData = 69'hA;
        applyStimulus(1);
        bInPc = 32'h0000_0204; bInCtrl = 8'h0B; bInData = 69'hB;
        applyStimulus(1);
        checkOutput("fl_full", bInReady, 1'b0);
        bInPc = 32'h0000_0208; bInCtrl = 8'h0C; bInData = 69'hC;
        flush = 1'b1;
        applyStimulus(1);
        flush = 1'b0; bInValid = 1'b0;
        checkOutput("fl_valid", bOutValid, 1'b0);
        checkOutput("fl_ctrl",  bOutCtrl,  8'h00);
        checkOutput("fl_ready", bInReady,  1'b1);
        bOutReady = 1'b1;
        applyStimulus(2);
        checkOutput("fl_noC", bOutValid, 1'b0);

        // Flush discards an input that fires in the same cycle.
        aOutReady = 1'b1;
        aInValid = 1'b1; aInPc = 32'h0000_0500; aInCtrl = 8'h55; aInData = 69'h5;
        flush = 1'b1;
        applyStimulus(1);
        flush = 1'b0; aInValid = 1'b0;
        checkOutput("fla_valid", aOutValid, 1'b0);
        checkOutput("fla_ctrl",  aOutCtrl,  8'h00);
        applyStimulus(1);
        checkOutput("fla_after", aOutValid, 1'b0);

        // Stall counter saturation on the 3-bit instance.
        cOutReady = 1'b0;
        cInValid = 1'b1; cInPc = 32'h0000_0300; cInCtrl = 8'h01; cInData = 69'h3;
        applyStimulus(1);
        cInValid = 1'b0;
        checkOutput("sat_start", cStall, 3'd0);
        applyStimulus(6);
        checkOutput("sat_six", cStall, 3'd6);
        applyStimulus(4);
        checkOutput("sat_hold", cStall, 3'd7);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("sat_reset", cStall,    3'd0);
        checkOutput("sat_valid", cOutValid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
